// File: rtl/encoder_bias_add_stream.sv
// Streaming bias adder: joins activation and bias lanes, adds, converts precision
// and saturates over two register stages, tagging the last beat of each row.
module encoder_bias_add_stream #(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int DATA_IN_PRECISION_1  = 3,
    parameter int BIAS_PRECISION_0     = 16,
    parameter int BIAS_PRECISION_1     = 3,
    parameter int DATA_OUT_PRECISION_0 = 16,
    parameter int DATA_OUT_PRECISION_1 = 3,
    parameter int TENSOR_SIZE_DIM_0    = 32,
    parameter int PARALLELISM_DIM_0    = 1,
    parameter int PARALLELISM_DIM_1    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    input  logic [BIAS_PRECISION_0-1:0]     bias [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    input  logic                            bias_valid,
    output logic                            bias_ready,
    output logic [DATA_OUT_PRECISION_0-1:0] data_out [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            data_out_last,
    output logic                            sat_flag
);
    localparam int P   = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
    localparam int DEP = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0;
    localparam int DW  = DATA_IN_PRECISION_0;
    localparam int BW  = BIAS_PRECISION_0;
    localparam int OW  = DATA_OUT_PRECISION_0;
    localparam int DI  = DATA_IN_PRECISION_0 - DATA_IN_PRECISION_1;
    localparam int BI  = BIAS_PRECISION_0 - BIAS_PRECISION_1;
    localparam int F   = (DATA_IN_PRECISION_1 > BIAS_PRECISION_1) ?
                         DATA_IN_PRECISION_1 : BIAS_PRECISION_1;
    localparam int I   = (DI > BI) ? DI : BI;
    localparam int SW  = I + F + 1;
    localparam int UP  = (DATA_OUT_PRECISION_1 > F) ? DATA_OUT_PRECISION_1 - F : 0;
    localparam int DN  = (F > DATA_OUT_PRECISION_1) ? F - DATA_OUT_PRECISION_1 : 0;
    localparam int XW0 = SW + UP;
    localparam int XW  = ((XW0 > OW) ? XW0 : OW) + 1;
    localparam int CW  = $clog2(DEP) + 1;

    localparam logic signed [XW-1:0] MAXV = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic [CW-1:0]        LAST = CW'(DEP - 1);

    logic                 s1_valid;
    logic                 s1_ready;
    logic                 s2_ready;
    logic                 fire;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        s1_cnt;
    logic [CW-1:0]        s2_cnt;
    logic signed [SW-1:0] s1_sum [P];
    logic signed [SW-1:0] sum_c  [P];
    logic signed [SW-1:0] a_ext  [P];
    logic signed [SW-1:0] b_ext  [P];
    logic signed [XW-1:0] wide   [P];
    logic [OW-1:0]        conv   [P];
    logic                 any_sat;

    assign s2_ready      = !data_out_valid || data_out_ready;
    assign s1_ready      = !s1_valid || s2_ready;
    assign fire          = data_in_valid && bias_valid && s1_ready;
    assign data_in_ready = bias_valid && s1_ready;
    assign bias_ready    = data_in_valid && s1_ready;
    assign data_out_last = data_out_valid && (s2_cnt == LAST);

    // Align both operands to F fraction bits; SW leaves one guard bit.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            a_ext[i] = {{(SW-DW){data_in[i][DW-1]}}, data_in[i]};
            b_ext[i] = {{(SW-BW){bias[i][BW-1]}}, bias[i]};
            sum_c[i] = (a_ext[i] <<< (F - DATA_IN_PRECISION_1))
                     + (b_ext[i] <<< (F - BIAS_PRECISION_1));
        end
    end

    // Arithmetic right shift floors toward -inf before the clamp.
    always_comb begin
        any_sat = 1'b0;
        for (int i = 0; i < P; i++) begin
            wide[i] = {{(XW-SW){s1_sum[i][SW-1]}}, s1_sum[i]};
            wide[i] = (wide[i] <<< UP) >>> DN;
            if (wide[i] > MAXV) begin
                conv[i] = MAXV[OW-1:0];
                any_sat = 1'b1;
            end else if (wide[i] < MINV) begin
                conv[i] = MINV[OW-1:0];
                any_sat = 1'b1;
            end else begin
                conv[i] = wide[i][OW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (fire) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cnt   <= '0;
            for (int i = 0; i < P; i++) s1_sum[i] <= '0;
        end else if (s1_ready) begin
            s1_valid <= fire;
            if (fire) begin
                s1_cnt <= cnt;
                for (int i = 0; i < P; i++) s1_sum[i] <= sum_c[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_valid <= 1'b0;
            s2_cnt         <= '0;
            sat_flag       <= 1'b0;
            for (int i = 0; i < P; i++) data_out[i] <= '0;
        end else if (s2_ready) begin
            data_out_valid <= s1_valid;
            if (s1_valid) begin
                s2_cnt   <= s1_cnt;
                sat_flag <= sat_flag | any_sat;
                for (int i = 0; i < P; i++) data_out[i] <= conv[i];
            end
        end
    end
endmodule

// File: tb/tb_encoder_bias_add_stream.sv
// Randomized scoreboard bench for encoder_bias_add_stream plus directed
// checks of latency, saturation, join, backpressure, reset and row tagging.
module tb_encoder_bias_add_stream;
    logic        clk = 0;
    logic        rst = 1;
    logic [15:0] din [1];
    logic [15:0] bin [1];
    logic [15:0] dout [1];
    logic        div = 0, bv = 0, din_rdy, b_rdy;
    logic        dout_v, dout_rdy = 1, dout_last, sat;
    logic [15:0] d2_in [1];
    logic [15:0] d2_b [1];
    logic [15:0] d2_out [1];
    logic        d2_iv = 0, d2_bv = 0, d2_ir, d2_br, d2_ov, d2_last, d2_sat;

    int total = 0;
    int bad = 0;
    int in_idx = 0;
    logic exp_sat = 0;
    logic rand_rdy = 0;
    logic hold = 0;
    logic [15:0] hold_d;
    logic hold_l;

    typedef struct {
        logic [15:0] d;
        logic        last;
        logic        sat;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    encoder_bias_add_stream dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(div), .data_in_ready(din_rdy),
        .bias(bin), .bias_valid(bv), .bias_ready(b_rdy),
        .data_out(dout), .data_out_valid(dout_v),
        .data_out_ready(dout_rdy), .data_out_last(dout_last),
        .sat_flag(sat)
    );

    encoder_bias_add_stream #(
        .BIAS_PRECISION_1(5),
        .TENSOR_SIZE_DIM_0(1)
    ) dut2 (
        .clk(clk), .rst(rst),
        .data_in(d2_in), .data_in_valid(d2_iv), .data_in_ready(d2_ir),
        .bias(d2_b), .bias_valid(d2_bv), .bias_ready(d2_br),
        .data_out(d2_out), .data_out_valid(d2_ov),
        .data_out_ready(1'b1), .data_out_last(d2_last),
        .sat_flag(d2_sat)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Real-number rule: align fractions, add, floor to output fraction, clamp.
    function automatic logic [16:0] ref_add(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input int af, input int bf,
                                            input int of);
        longint sa, sb, s;
        int f;
        logic sflag;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        f = (af > bf) ? af : bf;
        s = sa * (64'sd1 << (f - af)) + sb * (64'sd1 << (f - bf));
        if (of < f) s = s >>> (f - of);
        else s = s * (64'sd1 << (of - f));
        sflag = 0;
        if (s > 32767) begin s = 32767; sflag = 1; end
        if (s < -32768) begin s = -32768; sflag = 1; end
        return {sflag, s[15:0]};
    endfunction

    // Scoreboard: handshakes decided at the negedge complete on the next posedge.
    always @(negedge clk) begin
        exp_t e;
        logic [16:0] r;
        if (rst) begin
            q.delete();
            in_idx = 0;
            exp_sat = 0;
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", {31'b0, dout_v}, 1);
                chk("hold_data", {16'b0, dout[0]}, {16'b0, hold_d});
                chk("hold_last", {31'b0, dout_last}, {31'b0, hold_l});
            end
            hold = dout_v && !dout_rdy;
            hold_d = dout[0];
            hold_l = dout_last;
            if (dout_v && dout_rdy) begin
                if (q.size() == 0) begin
                    chk("extra_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    exp_sat = exp_sat | e.sat;
                    chk("data", {16'b0, dout[0]}, {16'b0, e.d});
                    chk("last", {31'b0, dout_last}, {31'b0, e.last});
                    chk("sat", {31'b0, sat}, {31'b0, exp_sat});
                end
            end
            if (div && bv && din_rdy) begin
                r = ref_add(din[0], bin[0], 3, 3, 3);
                e.d = r[15:0];
                e.sat = r[16];
                e.last = (in_idx % 32) == 31;
                q.push_back(e);
                in_idx++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) dout_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        logic hs;
        din[0] = a;
        bin[0] = b;
        div = 1;
        bv = 1;
        n = 0;
        do begin
            @(negedge clk);
            hs = din_rdy && b_rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) chk("send_timeout", 0, 1);
        div = 0;
        bv = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", q.size(), 0);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        din[0] = 0; bin[0] = 0; d2_in[0] = 0; d2_b[0] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_valid", {31'b0, dout_v}, 0);
        chk("rst_last", {31'b0, dout_last}, 0);
        chk("rst_sat", {31'b0, sat}, 0);
        chk("rst_data", {16'b0, dout[0]}, 0);

        // Two-cycle latency from fire.
        din[0] = 16'h0010; bin[0] = 16'h0008; div = 1; bv = 1;
        @(negedge clk);
        chk("lat_fire", {31'b0, din_rdy}, 1);
        @(posedge clk); #1; div = 0; bv = 0;
        chk("lat_c1_valid", {31'b0, dout_v}, 0);
        @(posedge clk); #1;
        chk("lat_c2_valid", {31'b0, dout_v}, 1);
        chk("lat_c2_data", {16'b0, dout[0]}, 32'h0018);
        chk("lat_c2_sat", {31'b0, sat}, 0);

        send(16'h7FF0, 16'h0020);
        send(16'h8000, 16'hFFF8);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("sat_sticky", {31'b0, sat}, 1);
        chk("sat_neg_data", {16'b0, dout[0]}, 32'h8000);

        // Fraction-width mismatch and single-beat rows.
        d2_in[0] = 16'h0010; d2_b[0] = 16'h0021; d2_iv = 1; d2_bv = 1;
        @(posedge clk); #1;
        d2_in[0] = 16'hFFF0; d2_b[0] = 16'hFFFF;
        @(posedge clk); #1; d2_iv = 0; d2_bv = 0;
        chk("d2_pos", {16'b0, d2_out[0]}, 32'h0018);
        chk("d2_pos_last", {31'b0, d2_last & d2_ov}, 1);
        @(posedge clk); #1;
        chk("d2_floor", {16'b0, d2_out[0]},
            {16'b0, ref_add(16'hFFF0, 16'hFFFF, 3, 5, 3)});
        chk("d2_floor_last", {31'b0, d2_last & d2_ov}, 1);

        pulse_rst();
        // Only one side valid: nothing joins.
        div = 1; din[0] = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            chk("join_din_rdy", {31'b0, din_rdy}, 0);
            chk("join_b_rdy", {31'b0, b_rdy}, 1);
            chk("join_no_out", {31'b0, dout_v}, 0);
        end
        @(posedge clk); #1; div = 0;

        // Both stages full, then ready rises and a beat enters that cycle.
        dout_rdy = 0;
        send(16'h0100, 16'h0001);
        send(16'h0200, 16'h0002);
        din[0] = 16'h0300; bin[0] = 16'h0003; div = 1; bv = 1;
        @(negedge clk);
        chk("full_din_rdy", {31'b0, din_rdy}, 0);
        chk("full_b_rdy", {31'b0, b_rdy}, 0);
        @(posedge clk); #1; dout_rdy = 1;
        @(negedge clk);
        chk("rise_din_rdy", {31'b0, din_rdy}, 1);
        chk("rise_b_rdy", {31'b0, b_rdy}, 1);
        @(posedge clk); #1; div = 0; bv = 0;
        drain();

        // Random stream under random backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            send(16'($urandom), 16'($urandom_range(0, 15) == 0 ?
                 $urandom : $urandom_range(0, 255)));
        end
        rand_rdy = 0;
        @(posedge clk); #1; dout_rdy = 1;
        drain();

        // Row tagging over two rows, starting from a fresh count.
        pulse_rst();
        for (int i = 0; i < 64; i++) send(16'(i), 16'h0008);
        drain();

        // Reset with output stalled and two beats in flight.
        pulse_rst();
        for (int i = 0; i < 10; i++)
            send(i == 3 ? 16'h7FF0 : 16'(i * 3), 16'h0020);
        drain();
        repeat (2) @(posedge clk);
        #1;
        dout_rdy = 0;
        send(16'h0011, 16'h0001);
        send(16'h0022, 16'h0002);
        @(negedge clk);
        chk("pre_rst_sat", {31'b0, sat}, 1);
        chk("pre_rst_valid", {31'b0, dout_v}, 1);
        pulse_rst();
        chk("post_rst_valid", {31'b0, dout_v}, 0);
        chk("post_rst_sat", {31'b0, sat}, 0);
        dout_rdy = 1;
        for (int i = 0; i < 32; i++) send(16'(i + 5), 16'h0001);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
